maxpool_ctrl: RTL and testbench
===============================

// Module: maxpool_ctrl
// PURPOSE
//  Sequences the registered 32-bit sign-magnitude max/ReLU unit over a KxK pooling window.
//  Scans a row-major feature map in on-chip memory and writes one pooled value per output position.
//  Sits between the feature-map memory and the max unit; it owns that unit's i1/i2/en inputs.
//  Negative data is clamped to 0 by the max unit, so each output is max(0, window).
// PARAMETERS
//  K       2   pooling window side (window = K*K elements), K>=1
//  S       2   stride in x and y, S>=1
//  DIM_W   8   width of cfg_w/cfg_h and of the internal x/y counters
//  ADDR_W  16  memory address width
// PORTS
//  clk          in   1       clock, all logic on posedge
//  rst          in   1       synchronous active-high reset
//  start        in   1       1-cycle pulse, begins a pooling pass (ignored while busy)
//  cfg_w        in   DIM_W   input width, sampled when start is accepted
//  cfg_h        in   DIM_W   input height, sampled when start is accepted
//  cfg_in_base  in   ADDR_W  input map base address, sampled when start is accepted
//  cfg_out_base in   ADDR_W  output map base address, sampled when start is accepted
//  rd_en        out  1       memory read strobe
//  rd_addr      out  ADDR_W  memory read address
//  rd_data      in   32      read data, valid exactly 1 cycle after rd_en
//  mx_i1        out  32      to max unit i1 (memory sample)
//  mx_i2        out  32      to max unit i2 (running max)
//  mx_en        out  1       to max unit en
//  mx_result    in   32      max unit output, registered, valid 1 cycle after mx_en
//  wr_en        out  1       output write strobe
//  wr_addr      out  ADDR_W  output write address
//  wr_data      out  32      pooled value
//  busy         out  1       high from the cycle after start acceptance through the last WR
//  done         out  1       1-cycle pulse after the last write, or for an empty pass
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; acc=0; counters=0.
//  Reset mid-pass: aborts immediately with no further rd_en/wr_en.
//  Dimensions: OW=(cfg_w-K)/S+1, OH=(cfg_h-K)/S+1, using integer division.
//  Empty pass: if cfg_w<K or cfg_h<K, go IDLE->DONE. No reads or writes occur.
//  FSM states and transitions:
//   IDLE: start=1 -> RD (or DONE if the pass is empty); set acc=0, ox=oy=kx=ky=0.
//   RD:   rd_en=1; rd_addr=in_base+(oy*S+ky)*W+ox*S+kx (mod 2^ADDR_W). -> CMP.
//   CMP:  mx_i1=rd_data, mx_i2=acc, mx_en=1. -> ACC.
//   ACC:  acc<=mx_result; advance kx, then ky.
//         Last window element -> WR; otherwise -> RD.
//   WR:   wr_en=1; wr_data=acc (post-ACC value); wr_addr=out_base+oy*OW+ox (mod 2^ADDR_W).
//         Clear acc and kx/ky; advance ox, then oy.
//         Last output position -> DONE; otherwise -> RD.
//   DONE: done=1 for one cycle, busy=0. -> IDLE.
//  Output rules outside the listed states:
//   rd_en=wr_en=mx_en=0.
//   mx_i1/mx_i2 are 0 when mx_en=0; mx_result is then ignored.
//  Timing:
//   Each window costs 3*K*K+1 cycles; elements are strictly serialised by the acc dependency.
//   Total pass = OW*OH*(3*K*K+1) cycles.
//   With start in cycle 0, the first RD is in cycle 1 and done follows the last WR.
//  Config latching: changes to cfg_* during busy have no effect.
//  Start handling:
//   start during busy or DONE is dropped, not queued.
//   start in the same cycle as rst is ignored.
//  Write order: row-major; wr_addr increments by 1 per write from out_base.
// TESTING
//  4x4 map holding values 0..15, K=S=2, bases 0/0x100, start in cycle 0:
//   -> writes 5,7,13,15 to 0x100..0x103; busy cycles 1..52; done in cycle 53.
//  Window {0x80000005,0x00000003,0x00000007,0x00000002} -> wr_data=0x00000007.
//  Window all negative {0x80000001,0x8000FFFF,0x80000002,0x80000003} -> wr_data=0x00000000.
//  cfg_w=1, cfg_h=4, K=2 -> done in cycle 1, with no rd_en or wr_en ever asserted.
//  cfg_in_base=0xFFFE, 2x2 map -> rd_addr sequence FFFE,FFFF,0000,0001 (wraps).
//  Reset asserted at cycle 20 of a 4x4 pass:
//   -> all outputs 0 from cycle 21 and no further writes.
//   A fresh start afterwards repeats the first test exactly.
//  start pulsed again at cycle 10 during busy -> ignored; only 4 writes total.

Source files
------------

// File: rtl/maxpool_ctrl.sv
// Sequences the registered sign-magnitude max/ReLU unit over KxK windows
// of a row-major feature map and writes one pooled value per output.
module maxpool_ctrl #(
    parameter int K      = 2,
    parameter int S      = 2,
    parameter int DIM_W  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_w,
    input  logic [DIM_W-1:0]  cfg_h,
    input  logic [ADDR_W-1:0] cfg_in_base,
    input  logic [ADDR_W-1:0] cfg_out_base,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic [31:0]       mx_i1,
    output logic [31:0]       mx_i2,
    output logic              mx_en,
    input  logic [31:0]       mx_result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, RD, CMP, ACC, WR, DONE} state_t;

    state_t            state_q;
    logic [DIM_W-1:0]  w_q, ow_q, oh_q;
    logic [DIM_W-1:0]  ox_q, oy_q, kx_q, ky_q;
    logic [ADDR_W-1:0] in_base_q, out_base_q, oidx_q;
    logic [31:0]       acc_q;
    logic              rd_en_q, mx_en_q, wr_en_q, busy_q, done_q;
    logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
    logic [31:0]       mx_i2_q, wr_data_q;

    logic [DIM_W-1:0]  ox_d, oy_d, kx_d, ky_d;
    logic [DIM_W-1:0]  ow_d, oh_d;
    logic [ADDR_W-1:0] row_d, col_d, rd_addr_d;
    logic              last_elem, last_pos, empty;

    assign last_elem = (kx_q == DIM_W'(K - 1)) && (ky_q == DIM_W'(K - 1));
    assign last_pos  = (ox_q == ow_q - DIM_W'(1)) && (oy_q == oh_q - DIM_W'(1));
    assign empty     = (cfg_w < DIM_W'(K)) || (cfg_h < DIM_W'(K));
    assign ow_d      = (cfg_w - DIM_W'(K)) / DIM_W'(S) + DIM_W'(1);
    assign oh_d      = (cfg_h - DIM_W'(K)) / DIM_W'(S) + DIM_W'(1);

    // Counter values for the next read, so rd_addr can be registered.
    always_comb begin
        ox_d = ox_q;
        oy_d = oy_q;
        kx_d = kx_q;
        ky_d = ky_q;
        if (state_q == ACC) begin
            if (kx_q == DIM_W'(K - 1)) begin
                kx_d = '0;
                ky_d = ky_q + DIM_W'(1);
            end else begin
                kx_d = kx_q + DIM_W'(1);
            end
        end else if (state_q == WR) begin
            kx_d = '0;
            ky_d = '0;
            if (ox_q == ow_q - DIM_W'(1)) begin
                ox_d = '0;
                oy_d = oy_q + DIM_W'(1);
            end else begin
                ox_d = ox_q + DIM_W'(1);
            end
        end
        row_d = ADDR_W'(oy_d) * ADDR_W'(S) + ADDR_W'(ky_d);
        col_d = ADDR_W'(ox_d) * ADDR_W'(S) + ADDR_W'(kx_d);
        rd_addr_d = in_base_q + row_d * ADDR_W'(w_q) + col_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            w_q        <= '0;
            ow_q       <= '0;
            oh_q       <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            kx_q       <= '0;
            ky_q       <= '0;
            in_base_q  <= '0;
            out_base_q <= '0;
            oidx_q     <= '0;
            acc_q      <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            mx_en_q    <= 1'b0;
            mx_i2_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            mx_en_q   <= 1'b0;
            mx_i2_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        w_q        <= cfg_w;
                        ow_q       <= ow_d;
                        oh_q       <= oh_d;
                        in_base_q  <= cfg_in_base;
                        out_base_q <= cfg_out_base;
                        ox_q       <= '0;
                        oy_q       <= '0;
                        kx_q       <= '0;
                        ky_q       <= '0;
                        oidx_q     <= '0;
                        acc_q      <= '0;
                        if (empty) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= RD;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= cfg_in_base;
                            busy_q    <= 1'b1;
                        end
                    end
                end
                RD: begin
                    state_q <= CMP;
                    mx_en_q <= 1'b1;
                    mx_i2_q <= acc_q;
                end
                CMP: state_q <= ACC;
                ACC: begin
                    acc_q <= mx_result;
                    kx_q  <= kx_d;
                    ky_q  <= ky_d;
                    if (last_elem) begin
                        state_q   <= WR;
                        wr_en_q   <= 1'b1;
                        wr_data_q <= mx_result;
                        wr_addr_q <= out_base_q + oidx_q;
                    end else begin
                        state_q   <= RD;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= rd_addr_d;
                    end
                end
                WR: begin
                    acc_q  <= '0;
                    kx_q   <= '0;
                    ky_q   <= '0;
                    ox_q   <= ox_d;
                    oy_q   <= oy_d;
                    oidx_q <= oidx_q + ADDR_W'(1);
                    if (last_pos) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q   <= RD;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= rd_addr_d;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read data only arrives in the compare cycle, so i1 bypasses the registers.
    assign mx_i1   = mx_en_q ? rd_data : '0;
    assign mx_i2   = mx_i2_q;
    assign mx_en   = mx_en_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Directed bench for maxpool_ctrl with a memory model and a
// sign-magnitude max/ReLU unit model.
module tb_maxpool_ctrl;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [7:0]  cfg_w, cfg_h;
    logic [15:0] cfg_in_base, cfg_out_base;
    logic        rd_en, mx_en, wr_en, busy, done;
    logic [15:0] rd_addr, wr_addr;
    logic [31:0] rd_data, mx_i1, mx_i2, mx_result, wr_data;

    maxpool_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_w(cfg_w), .cfg_h(cfg_h),
        .cfg_in_base(cfg_in_base), .cfg_out_base(cfg_out_base),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .mx_i1(mx_i1), .mx_i2(mx_i2), .mx_en(mx_en),
        .mx_result(mx_result),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [0:65535];
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 32'h0BAD_F00D;

    function automatic logic [31:0] smax(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb;
        ma = a[31] ? 32'd0 : a;
        mb = b[31] ? 32'd0 : b;
        return (ma > mb) ? ma : mb;
    endfunction

    always @(posedge clk)
        if (rst) mx_result <= '0;
        else if (mx_en) mx_result <= smax(mx_i1, mx_i2);

    wire [132:0] outs = {rd_en, rd_addr, mx_i1, mx_i2, mx_en,
                         wr_en, wr_addr, wr_data, busy, done};

    int checks = 0;
    int errors = 0;

    logic [15:0] rdq[$];
    logic [15:0] wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    int first_busy, last_busy, nbusy, done_cyc, mxbad;

    task automatic run_pass(input int budget, input int pulse_at);
        int t0, rel;
        rdq.delete(); wa.delete(); wd.delete(); wc.delete();
        first_busy = -1; last_busy = -1; nbusy = 0; done_cyc = -1; mxbad = 0;
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            rel = cyc - t0;
            start = (rel == pulse_at);
            if (rel == pulse_at) begin
                cfg_w = 8'd2;
                cfg_out_base = 16'h0500;
            end
            if (rd_en) rdq.push_back(rd_addr);
            if (wr_en) begin
                wa.push_back(wr_addr);
                wd.push_back(wr_data);
                wc.push_back(rel);
            end
            if (busy) begin
                if (first_busy < 0) first_busy = rel;
                last_busy = rel;
                nbusy++;
            end
            if (!mx_en && (mx_i1 !== 32'd0 || mx_i2 !== 32'd0)) mxbad++;
            if (done) begin
                done_cyc = rel;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic setup_4x4();
        for (int i = 0; i < 16; i++) mem[i] = i;
        cfg_w = 8'd4; cfg_h = 8'd4;
        cfg_in_base = 16'h0000; cfg_out_base = 16'h0100;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_basic(input int pulse_at);
        int exp_rd[16] = '{0,1,4,5, 2,3,6,7, 8,9,12,13, 10,11,14,15};
        int exp_wd[4]  = '{5, 7, 13, 15};
        int exp_wc[4]  = '{13, 26, 39, 52};
        int bad;
        setup_4x4();
        run_pass(200, pulse_at);
        checks++;
        if (done_cyc !== 53) begin
            errors++;
            $display("FAIL basic_done_cycle: got %0d want 53", done_cyc);
        end
        checks++;
        if (first_busy !== 1 || last_busy !== 52 || nbusy !== 52) begin
            errors++;
            $display("FAIL basic_busy: first %0d last %0d n %0d want 1 52 52",
                     first_busy, last_busy, nbusy);
        end
        checks++;
        if (wa.size() !== 4) begin
            errors++;
            $display("FAIL basic_write_count: got %0d want 4", wa.size());
        end
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            checks++;
            if (wa[i] !== 16'h0100 + 16'(i) || wd[i] !== 32'(exp_wd[i]) || wc[i] !== exp_wc[i]) begin
                errors++;
                $display("FAIL basic_write%0d: got %h=%h @%0d want %h=%h @%0d",
                         i, wa[i], wd[i], wc[i], 16'h0100 + 16'(i), exp_wd[i], exp_wc[i]);
            end
        end
        bad = (rdq.size() == 16) ? 0 : 1;
        for (int i = 0; i < 16 && i < rdq.size(); i++)
            if (rdq[i] !== 16'(exp_rd[i])) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL basic_read_seq: %0d reads, %0d wrong, want 16 in window order",
                     rdq.size(), bad);
        end
        checks++;
        if (mxbad !== 0) begin
            errors++;
            $display("FAIL basic_mx_gating: %0d cycles with i1/i2 nonzero while en=0, want 0", mxbad);
        end
    endtask

    task automatic test_window(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic [31:0] d,
                               input logic [31:0] expv);
        mem[16'h0200] = a; mem[16'h0201] = b;
        mem[16'h0202] = c; mem[16'h0203] = d;
        cfg_w = 8'd2; cfg_h = 8'd2;
        cfg_in_base = 16'h0200; cfg_out_base = 16'h0300;
        run_pass(100, -1);
        checks++;
        if (wa.size() !== 1 || wd[0] !== expv || wa[0] !== 16'h0300 || done_cyc !== 14) begin
            errors++;
            $display("FAIL window_max: n=%0d data %h addr %h done %0d want 1 %h 0300 14",
                     wa.size(), wd.size() ? wd[0] : 32'hx, wa.size() ? wa[0] : 16'hx,
                     done_cyc, expv);
        end
    endtask

    task automatic test_empty();
        cfg_w = 8'd1; cfg_h = 8'd4;
        cfg_in_base = 16'h0000; cfg_out_base = 16'h0100;
        run_pass(20, -1);
        checks++;
        if (done_cyc !== 1 || rdq.size() !== 0 || wa.size() !== 0 || nbusy !== 0) begin
            errors++;
            $display("FAIL empty_pass: done %0d reads %0d writes %0d busy %0d want 1 0 0 0",
                     done_cyc, rdq.size(), wa.size(), nbusy);
        end
    endtask

    task automatic test_wrap();
        mem[16'hFFFE] = 32'd1; mem[16'hFFFF] = 32'd9;
        mem[16'h0000] = 32'd4; mem[16'h0001] = 32'd2;
        cfg_w = 8'd2; cfg_h = 8'd2;
        cfg_in_base = 16'hFFFE; cfg_out_base = 16'h0040;
        run_pass(100, -1);
        checks++;
        if (rdq.size() !== 4 || rdq[0] !== 16'hFFFE || rdq[1] !== 16'hFFFF ||
            rdq[2] !== 16'h0000 || rdq[3] !== 16'h0001) begin
            errors++;
            $display("FAIL wrap_reads: n=%0d first %h last %h want 4 FFFE..0001",
                     rdq.size(), rdq.size() ? rdq[0] : 16'hx,
                     rdq.size() ? rdq[rdq.size()-1] : 16'hx);
        end
        checks++;
        if (wa.size() !== 1 || wd[0] !== 32'd9) begin
            errors++;
            $display("FAIL wrap_data: n=%0d data %h want 1 9",
                     wa.size(), wd.size() ? wd[0] : 32'hx);
        end
    endtask

    task automatic test_odd_dims();
        for (int i = 0; i < 15; i++) mem[16'h0400 + 16'(i)] = 32'(i * 3);
        cfg_w = 8'd5; cfg_h = 8'd3;
        cfg_in_base = 16'h0400; cfg_out_base = 16'h0600;
        run_pass(200, -1);
        checks++;
        if (wa.size() !== 2 || done_cyc !== 27 || rdq.size() !== 8) begin
            errors++;
            $display("FAIL odd_shape: writes %0d done %0d reads %0d want 2 27 8",
                     wa.size(), done_cyc, rdq.size());
        end
        checks++;
        if (wa.size() == 2 && (wd[0] !== 32'd18 || wd[1] !== 32'd24 ||
            wa[0] !== 16'h0600 || wa[1] !== 16'h0601)) begin
            errors++;
            $display("FAIL odd_data: %h=%h %h=%h want 0600=18 0601=24",
                     wa[0], wd[0], wa[1], wd[1]);
        end
    endtask

    task automatic test_reset_mid();
        int t0, rel, nw, bad;
        setup_4x4();
        nw = 0; bad = 0;
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            start = 1'b0;
            rel = cyc - t0;
            if (wr_en) nw++;
            if (rel >= 21 && outs !== '0) bad++;
            rst = (rel == 20);
        end
        rst = 1'b0;
        checks++;
        if (nw !== 1 || bad !== 0) begin
            errors++;
            $display("FAIL reset_mid: writes %0d nonzero-cycles %0d want 1 0", nw, bad);
        end
    endtask

    task automatic test_start_with_rst();
        int bad;
        bad = 0;
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        cfg_w = 8'd4; cfg_h = 8'd4;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (busy || rd_en || done) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL start_with_rst: %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        test_basic(10);
        bad = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (busy || wr_en || rd_en) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL restart_dropped: %0d active cycles after done want 0", bad);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        cfg_w = '0; cfg_h = '0; cfg_in_base = '0; cfg_out_base = '0;
        test_reset();
        test_basic(-1);
        test_window(32'h8000_0005, 32'h0000_0003, 32'h0000_0007, 32'h0000_0002, 32'h0000_0007);
        test_window(32'h8000_0001, 32'h8000_FFFF, 32'h8000_0002, 32'h8000_0003, 32'h0000_0000);
        test_empty();
        test_wrap();
        test_odd_dims();
        test_reset_mid();
        test_basic(-1);
        test_start_with_rst();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
